// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode constants and output format codes for the immediate generator.
package imm_gen_pipe_pkg;

  localparam int FMT_W = 3;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Producer/consumer handshake bundle around the immediate generator FIFO.
interface imm_gen_pipe_if
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  fmt_e             out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt,
    input  out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt,
    output out_illegal, out_tag
  );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV immediate decode (instr -> imm, fmt, illegal).
// IMMGEN_BJ_SHIFT_EN selects byte (defined) or half-word B/J offsets.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [31:0] imm32;
  logic        s;

  assign s       = instr[31];
  assign illegal = (instr[1:0] != 2'b11);

  always_comb begin
    fmt = FMT_NONE;
    unique case (instr[6:0])
      OP_LOAD,
      OP_IMM,
      OP_JALR:   fmt = FMT_I;
      OP_IMM_32: fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
      OP_STORE:  fmt = FMT_S;
      OP_BRANCH: fmt = FMT_B;
      OP_LUI,
      OP_AUIPC:  fmt = FMT_U;
      OP_JAL:    fmt = FMT_J;
      default:   fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    imm32 = '0;
    unique case (fmt)
      FMT_I: imm32 = {{20{s}}, instr[31:20]};
      FMT_S: imm32 = {{20{s}}, instr[31:25], instr[11:7]};
      FMT_U: imm32 = {instr[31:12], 12'h000};
`ifdef IMMGEN_BJ_SHIFT_EN
      FMT_B: imm32 = {{19{s}}, s, instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_J: imm32 = {{11{s}}, s, instr[19:12], instr[20],
                      instr[30:21], 1'b0};
`else
      FMT_B: imm32 = {{20{s}}, s, instr[7], instr[30:25],
                      instr[11:8]};
      FMT_J: imm32 = {{12{s}}, s, instr[19:12], instr[20],
                      instr[30:21]};
`endif
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator: decode on entry, then a two-entry registered FIFO.
// Optional IMMGEN_BJ_SHIFT_EN makes B/J immediates byte offsets.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);

  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  logic             dec_ill;

  logic [XLEN-1:0]  imm_q [2];
  logic [XLEN-1:0]  imm_d [2];
  fmt_e             fmt_q [2];
  fmt_e             fmt_d [2];
  logic             ill_q [2];
  logic             ill_d [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [TAG_W-1:0] tag_d [2];

  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  fmt_e             out_fmt_q, out_fmt_d;
  logic             out_ill_q, out_ill_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             push, pop;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  assign bus.in_ready    = (count_q != 2'd2);
  assign bus.out_valid   = (count_q != 2'd0);
  assign bus.out_imm     = out_imm_q;
  assign bus.out_fmt     = out_fmt_q;
  assign bus.out_illegal = out_ill_q;
  assign bus.out_tag     = out_tag_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    imm_d   = imm_q;
    fmt_d   = fmt_q;
    ill_d   = ill_q;
    tag_d   = tag_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        imm_d[tail_q] = dec_imm;
        fmt_d[tail_q] = dec_fmt;
        ill_d[tail_q] = dec_ill;
        tag_d[tail_q] = bus.in_tag;
        tail_d        = ~tail_q;
      end
      if (pop) head_d = ~head_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Output registers follow the next head; they hold when the FIFO empties.
  always_comb begin
    out_imm_d = out_imm_q;
    out_fmt_d = out_fmt_q;
    out_ill_d = out_ill_q;
    out_tag_d = out_tag_q;
    if (count_d != 2'd0) begin
      out_imm_d = imm_d[head_d];
      out_fmt_d = fmt_d[head_d];
      out_ill_d = ill_d[head_d];
      out_tag_d = tag_d[head_d];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imm_q     <= '{default: '0};
      fmt_q     <= '{default: FMT_NONE};
      ill_q     <= '{default: 1'b0};
      tag_q     <= '{default: '0};
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= 2'd0;
      out_imm_q <= '0;
      out_fmt_q <= FMT_NONE;
      out_ill_q <= 1'b0;
      out_tag_q <= '0;
    end else begin
      imm_q     <= imm_d;
      fmt_q     <= fmt_d;
      ill_q     <= ill_d;
      tag_q     <= tag_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      out_imm_q <= out_imm_d;
      out_fmt_q <= out_fmt_d;
      out_ill_q <= out_ill_d;
      out_tag_q <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe (XLEN=64) plus a 32-bit decode check.
// Honours IMMGEN_BJ_SHIFT_EN in its reference model.
module tb_imm_gen_pipe;
  import imm_gen_pipe_pkg::*;

  localparam int XLEN  = 64;
  localparam int TAG_W = 4;

  typedef struct {
    logic [63:0]      imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic [31:0] d32_instr;
  logic [31:0] d32_imm;
  fmt_e        d32_fmt;
  logic        d32_ill;

  imm_gen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  imm_decode #(.XLEN(32)) u_dec32 (
    .instr   (d32_instr),
    .imm     (d32_imm),
    .fmt     (d32_fmt),
    .illegal (d32_ill)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(logic [31:0] i, logic [TAG_W-1:0] t);
    exp_t e;
    logic signed [63:0] v;
    v     = '0;
    e.fmt = 3'd0;
    e.tag = t;
    e.ill = (i[1:0] != 2'b11);
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h1B: begin
        e.fmt = 3'd1;
        v = {{52{i[31]}}, i[31:20]};
      end
      7'h23: begin
        e.fmt = 3'd2;
        v = {{52{i[31]}}, i[31:25], i[11:7]};
      end
      7'h63: begin
        e.fmt = 3'd3;
        v = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
`ifndef IMMGEN_BJ_SHIFT_EN
        v = v >>> 1;
`endif
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        v = {{32{i[31]}}, i[31:12], 12'h000};
      end
      7'h6F: begin
        e.fmt = 3'd5;
        v = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
`ifndef IMMGEN_BJ_SHIFT_EN
        v = v >>> 1;
`endif
      end
      default: v = '0;
    endcase
    e.imm = v;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("imm", bus.out_imm, e.imm);
            check("fmt", 64'(bus.out_fmt), 64'(e.fmt));
            check("ill", 64'(bus.out_illegal), 64'(e.ill));
            check("tag", 64'(bus.out_tag), 64'(e.tag));
          end
        end
        if (bus.in_valid && bus.in_ready)
          sb.push_back(model(bus.in_instr, bus.in_tag));
      end
    end
  end

  task automatic send(logic [31:0] instr, logic [TAG_W-1:0] tag);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_tag   = tag;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [10];
  initial begin
    ops = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23,
            7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
  end

  initial begin
    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    d32_instr     = '0;

    #7;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_imm", bus.out_imm, 64'd0);
    check("rst_out_fmt", 64'(bus.out_fmt), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_out_ill", 64'(bus.out_illegal), 64'd0);
    #5;
    reset_n = 1'b1;
    step();

    bus.out_ready = 1'b1;
    send(32'hFFF00093, 4'd1);
    @(negedge clk);
    check("addi_valid", 64'(bus.out_valid), 64'd1);
    check("addi_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_fmt", 64'(bus.out_fmt), 64'd1);
    step();

    send(32'hFE000EE3, 4'd2);
    @(negedge clk);
    check("beq_fmt", 64'(bus.out_fmt), 64'd3);
`ifdef IMMGEN_BJ_SHIFT_EN
    check("beq_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
`else
    check("beq_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFE);
`endif
    step();

    send(32'h123450B7, 4'd3);
    @(negedge clk);
    check("lui_imm", bus.out_imm, 64'h0000_0000_1234_5000);
    check("lui_fmt", 64'(bus.out_fmt), 64'd4);
    step();

    d32_instr = 32'h0000001B;
    #1;
    check("x32_addiw_fmt", 64'(d32_fmt), 64'd0);
    check("x32_addiw_imm", 64'(d32_imm), 64'd0);
    d32_instr = 32'hFFF00093;
    #1;
    check("x32_addi_imm", 64'(d32_imm), 64'hFFFF_FFFF);

    // Back-pressure: tags 1,2 fill the FIFO, tag 3 waits.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00100013;
    bus.in_tag    = 4'd1;
    step();
    bus.in_tag    = 4'd2;
    step();
    bus.in_tag    = 4'd3;
    @(negedge clk);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_head_tag", 64'(bus.out_tag), 64'd1);
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_still_full", 64'(bus.in_ready), 64'd0);
    step();
    @(negedge clk);
    check("bp_tag3_ready", 64'(bus.in_ready), 64'd1);
    check("bp_head2", 64'(bus.out_tag), 64'd2);
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    // Flush at count=2 with a simultaneous push.
    bus.out_ready = 1'b0;
    send(32'h00200013, 4'd4);
    send(32'h00300013, 4'd5);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00400013;
    bus.in_tag   = 4'd6;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_ready", 64'(bus.in_ready), 64'd1);
    step();
    step();
    check("flush_dropped", 64'(bus.out_valid), 64'd0);

    // Reset pulse with one entry buffered.
    send(32'h00500013, 4'd7);
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_ready", 64'(bus.in_ready), 64'd1);
    check("arst_imm", bus.out_imm, 64'd0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    step();
    step();
    check("post_rst_valid", 64'(bus.out_valid), 64'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) r[1:0] = 2'($urandom_range(0, 2));
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_instr  = r;
      bus.in_tag    = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("end_idle", 64'(bus.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 64, immediate width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried with each instruction.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  in_instr/in_tag are valid.
REQ-007 in_ready  output  1  block accepts an entry this cycle.
REQ-008 in_instr  input  32  RV instruction word.
REQ-009 in_tag  input  TAG_W  opaque sideband, returned unchanged.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  consumer accepts the head entry.
REQ-012 out_imm  output  XLEN  sign-extended immediate.
REQ-013 out_fmt  output  3  format code: NONE=0, I=1, S=2, B=3, U=4, J=5.
REQ-014 out_illegal  output  1  instr[1:0] != 2'b11.
REQ-015 out_tag  output  TAG_W  tag of the head entry.

Function
REQ-016 Decode on opcode instr[6:0]: 0000011/0010011/1100111 -> I; 0011011 -> I only when XLEN=64, else NONE; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; all other opcodes -> NONE.
REQ-017 I: sext(instr[31:20]). S: sext({instr[31:25],instr[11:7]}). U: sext({instr[31:12],12'b0}). NONE: all zeros.
REQ-018 Sign extension always replicates instr[31] up to bit XLEN-1.
REQ-019 Decode is performed on input and stored; outputs come only from buffer registers, with no combinational path from in_* to out_*.
REQ-020 Two-entry in-order FIFO; count in {0,1,2}; in_ready = (count != 2); out_valid = (count != 0); both outputs driven from registers.
REQ-021 Push on in_valid && in_ready; pop on out_valid && out_ready; push and pop in the same cycle leave count unchanged and preserve order.
REQ-022 Latency: an entry pushed in cycle N is visible on out_* in cycle N+1 if the FIFO was empty.
REQ-023 Full (count=2): in_ready=0 and in_instr is ignored. Empty: out_imm/out_fmt/out_tag/out_illegal hold their last values and carry no meaning.
REQ-024 flush=1: count becomes 0 next cycle; it overrides a same-cycle push and pop; in_ready stays as the registered value for that cycle.
REQ-025 Head/tail pointers are 1 bit and wrap modulo 2.

Reset
REQ-026 On reset_n=0, immediately: count=0, pointers=0, out_valid=0, in_ready=1, out_imm=0, out_fmt=NONE, out_tag=0, out_illegal=0.
REQ-027 Reset asserted mid-transfer discards all entries; no partial entry is presented after release.

Configuration
REQ-028 Macro IMMGEN_BJ_SHIFT_EN, when defined: B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}) and J = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}), giving byte offsets.
REQ-029 When undefined: the same fields without the trailing 1'b0, giving half-word offsets; the consumer shifts.

Structure
REQ-030 A shared package holds the opcode constants, the out_fmt enumeration and the fmt width.
REQ-031 One sub-module, imm_decode, is purely combinational (instr -> imm, fmt, illegal) and parametrised by XLEN; the FIFO lives in imm_gen_pipe.

Verification
REQ-032 XLEN=64, push 0xFFF00093 (addi -1) to an empty FIFO -> next cycle out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, out_fmt=1.
REQ-033 Push 0xFE000EE3 (beq -4) -> out_fmt=3; out_imm=0xFFFFFFFFFFFFFFFC with IMMGEN_BJ_SHIFT_EN, 0xFFFFFFFFFFFFFFFE without.
REQ-034 Push 0x123450B7 (lui) -> out_imm=0x0000000012345000, fmt=4; with XLEN=32, 0x0000001B -> fmt=0, imm=0.
REQ-035 out_ready=0, offer tags 1,2,3 -> 1 and 2 accepted, in_ready=0; raise out_ready -> tags 1,2 pop in order, then 3 is accepted.
REQ-036 count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, new entry dropped; separately, reset_n pulse at count=1 -> out_valid=0 immediately.
